gg_cell: RTL and testbench

- Diagonal boundary cell of the CORDIC QR systolic array. Runs CORDIC in vectoring mode.
- Holds the running diagonal element r_ii and annihilates each incoming sub-diagonal sample a_i.
- Emits the per-iteration rotation directions, 4 bits per cycle, together with rotates/valid strobes. The GR cells in the same row consume these to replay the identical rotation.
- After a fixed number of samples, presents the K-scaled r_ii and pulses done.

---
 rtl/gg_cell.sv | 191 +++++++++++++++++++
 tb/tb_gg_cell.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gg_cell.sv
// Diagonal boundary cell of the CORDIC QR array (vectoring mode).
// Keeps r_ii, annihilates each sample and streams rotation directions.
module gg_cell #(
  parameter int D_WIDTH    = 4,
  parameter int DATA_WIDTH = 20,
  parameter int N_ROWS     = 4,
  parameter logic [DATA_WIDTH-1:0] K = 20'b0000000000_1001101101
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [D_WIDTH-1:0]    d_o,
  output logic                  rotates_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] r_o,
  output logic [DATA_WIDTH-1:0] y_res_o,
  output logic                  done_o
);

  localparam int N_CYC = 3;
  localparam int CW    = 2;
  localparam int SW    = $clog2(N_CYC * D_WIDTH);
  localparam int RW    = $clog2(N_ROWS + 1);
  localparam int FRAC  = 10;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int MSB   = DATA_WIDTH - 1;

  localparam logic signed [PW-1:0] KE =
    {{DATA_WIDTH{K[MSB]}}, K};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_SCALE
  } state_t;

  state_t                        r_state;
  logic [CW-1:0]                 r_cnt;
  logic [RW-1:0]                 r_rows;
  logic                          r_first;
  logic [DATA_WIDTH-1:0]         r_a;
  logic signed [DATA_WIDTH-1:0]  r_x;
  logic signed [DATA_WIDTH-1:0]  r_y;
  logic [D_WIDTH-1:0]            r_d;
  logic                          r_rot;
  logic                          r_vld;
  logic                          r_done;

  logic signed [DATA_WIDTH-1:0]  w_xc;
  logic signed [DATA_WIDTH-1:0]  w_yc;
  logic signed [DATA_WIDTH-1:0]  w_xs;
  logic signed [DATA_WIDTH-1:0]  w_ys;
  logic [SW-1:0]                 w_sh;
  logic [D_WIDTH-1:0]            w_d;

  logic signed [PW-1:0]          w_xe;
  logic signed [PW-1:0]          w_ye;
  logic signed [PW-1:0]          w_px;
  logic signed [PW-1:0]          w_py;
  logic signed [DATA_WIDTH-1:0]  w_xk;
  logic signed [DATA_WIDTH-1:0]  w_yk;
  logic                          w_unused;

  // Chain of D_WIDTH vectoring micro-steps for the current ITER cycle.
  always_comb begin
    w_xc = r_x;
    w_yc = r_y;
    w_xs = '0;
    w_ys = '0;
    w_sh = '0;
    w_d  = '0;
    for (int j = 0; j < D_WIDTH; j++) begin
      w_sh = SW'(int'(r_cnt) * D_WIDTH + j);
      w_xs = w_xc >>> w_sh;
      w_ys = w_yc >>> w_sh;
      w_d[j] = w_xc[MSB] ^ w_yc[MSB];
      if (w_d[j]) begin
        w_xc = w_xc - w_ys;
        w_yc = w_yc + w_xs;
      end else begin
        w_xc = w_xc + w_ys;
        w_yc = w_yc - w_xs;
      end
    end
  end

  assign w_xe = {{DATA_WIDTH{r_x[MSB]}}, r_x};
  assign w_ye = {{DATA_WIDTH{r_y[MSB]}}, r_y};
  assign w_px = w_xe * KE;
  assign w_py = w_ye * KE;

  // Keep sign, drop the fraction of K and the wrapped integer bits.
  assign w_xk = {w_px[PW-1], w_px[DATA_WIDTH+FRAC-2:FRAC]};
  assign w_yk = {w_py[PW-1], w_py[DATA_WIDTH+FRAC-2:FRAC]};

  assign w_unused = ^{w_px[PW-2:DATA_WIDTH+FRAC-1],
                      w_px[FRAC-1:0],
                      w_py[PW-2:DATA_WIDTH+FRAC-1],
                      w_py[FRAC-1:0]};

  // Control FSM plus datapath and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rows  <= '0;
      r_first <= 1'b1;
      r_a     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_d     <= '0;
      r_rot   <= 1'b0;
      r_vld   <= 1'b0;
      r_done  <= 1'b0;
    end else if (clr_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rows  <= '0;
      r_first <= 1'b1;
      r_a     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_d     <= '0;
      r_rot   <= 1'b0;
      r_vld   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rot  <= 1'b0;
      r_vld  <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            if (r_first) begin
              r_a     <= a_i;
              r_state <= S_LOAD;
            end else begin
              r_y     <= a_i;
              r_cnt   <= '0;
              r_state <= S_ITER;
            end
          end
        end
        S_LOAD: begin
          r_x     <= r_a;
          r_first <= 1'b0;
          r_rows  <= r_rows + RW'(1);
          r_state <= S_IDLE;
        end
        S_ITER: begin
          r_x   <= w_xc;
          r_y   <= w_yc;
          r_d   <= w_d;
          r_rot <= 1'b1;
          r_vld <= (r_cnt == '0);
          if (r_cnt == CW'(N_CYC - 1)) begin
            r_state <= S_SCALE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SCALE: begin
          r_x <= w_xk;
          r_y <= w_yk;
          if (r_rows == RW'(N_ROWS - 1)) begin
            r_done  <= 1'b1;
            r_rows  <= '0;
            r_first <= 1'b1;
          end else begin
            r_rows <= r_rows + RW'(1);
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o   = (r_state == S_IDLE);
  assign d_o       = r_d;
  assign rotates_o = r_rot;
  assign valid_o   = r_vld;
  assign r_o       = r_x;
  assign y_res_o   = r_y;
  assign done_o    = r_done;

endmodule

// File: tb/tb_gg_cell.sv
// Bench for gg_cell: reset/clear, directed vectors, random columns,
// column completion and busy handling against a reference model.
module tb_gg_cell;

  localparam int NR = 4;

  logic        clk;
  logic        rst;
  logic        clr_i;
  logic [19:0] a_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  d_o;
  logic        rotates_o;
  logic        valid_o;
  logic [19:0] r_o;
  logic [19:0] y_res_o;
  logic        done_o;

  gg_cell dut (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr_i),
    .a_i       (a_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .d_o       (d_o),
    .rotates_o (rotates_o),
    .valid_o   (valid_o),
    .r_o       (r_o),
    .y_res_o   (y_res_o),
    .done_o    (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  bit m_first;
  int m_rows;
  int m_x;
  logic [3:0] got_d0;

  typedef struct {
    int         x0;
    int         a;
    logic [3:0] d0;
    int         r;
    int         tol;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_tol(input string nm, input int act, input int exp,
                         input int tol);
    n_vec++;
    if (act > exp + tol || act < exp - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d +/-%0d", nm, act, exp, tol);
    end
  endtask

  function automatic int sval(input logic [19:0] v);
    logic signed [19:0] t;
    t = v;
    return int'(t);
  endfunction

  function automatic int wrap(input int v);
    logic signed [19:0] t;
    t = v[19:0];
    return int'(t);
  endfunction

  // Multiply by K = 621/1024, keep {P[39], P[28:10]}.
  function automatic int kscale(input int v);
    longint p;
    logic [63:0] pb;
    logic signed [19:0] t;
    p  = longint'(v) * 64'sd621;
    pb = p;
    t  = {pb[39], pb[28:10]};
    return int'(t);
  endfunction

  // Twelve vectoring micro-rotations followed by gain compensation.
  task automatic model_rot(input int x0, input int y0,
                           output int xo, output int yo,
                           output logic [11:0] d);
    int x;
    int y;
    int nx;
    int ny;
    x = x0;
    y = y0;
    d = '0;
    for (int s = 0; s < 12; s++) begin
      d[s] = ((x < 0) != (y < 0));
      if (!d[s]) begin
        nx = x + (y >>> s);
        ny = y - (x >>> s);
      end else begin
        nx = x - (y >>> s);
        ny = y + (x >>> s);
      end
      x = wrap(nx);
      y = wrap(ny);
    end
    xo = kscale(x);
    yo = kscale(y);
  endtask

  task automatic model_reset();
    m_first = 1'b1;
    m_rows  = 0;
    m_x     = 0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    model_reset();
  endtask

  // Offer one sample and check the full response cycle by cycle.
  task automatic sample(input int a, input bit junk);
    int k;
    int xo;
    int yo;
    logic [11:0] d;
    bit exp_done;
    k = 0;
    while (!ready_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", int'(ready_o), 1);
    valid_i = 1'b1;
    a_i = 20'(a);
    @(negedge clk);
    valid_i = junk;
    a_i = 20'($urandom);
    if (m_first) begin
      chk("load_busy", int'(ready_o), 0);
      chk("load_rot", int'(rotates_o), 0);
      @(negedge clk);
      valid_i = 1'b0;
      chk("load_r", sval(r_o), wrap(a));
      chk("load_ready", int'(ready_o), 1);
      chk("load_rot2", int'(rotates_o), 0);
      m_x = wrap(a);
      m_first = 1'b0;
      m_rows = 1;
    end else begin
      model_rot(m_x, wrap(a), xo, yo, d);
      m_rows++;
      exp_done = (m_rows == NR);
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        chk("rot_on", int'(rotates_o), 1);
        chk("valid_o", int'(valid_o), int'(c == 1));
        chk("d_o", int'(d_o), int'(d[4*(c-1) +: 4]));
        if (c == 1) got_d0 = d_o;
      end
      @(negedge clk);
      valid_i = 1'b0;
      chk("rot_off", int'(rotates_o), 0);
      chk("r_o", sval(r_o), xo);
      chk("y_res", sval(y_res_o), yo);
      chk("done", int'(done_o), int'(exp_done));
      m_x = xo;
      if (exp_done) begin
        m_rows = 0;
        m_first = 1'b1;
        @(negedge clk);
        chk("done_pulse", int'(done_o), 0);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int av;
    int nd;
    int q[$];
    int acc_exp;
    int rot_cnt;
    int done_cnt;
    int rot_exp;
    int done_exp;
    int tt;
    int xo;
    int yo;
    logic [11:0] dd;

    tbl[0] = '{4096,  3072, 4'b0010, 5120, 16};
    tbl[1] = '{4096, -3072, 4'b1101, 5120, 16};
    tbl[2] = '{3072,  4096, 4'b1100, 5120, 16};
    tbl[3] = '{4096,     0, 4'b1110, 4096, 16};

    rst = 1'b1;
    clr_i = 1'b0;
    valid_i = 1'b0;
    a_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_r", int'(r_o), 0);
    chk("rst_y", int'(y_res_o), 0);
    chk("rst_d", int'(d_o), 0);
    chk("rst_rot", int'(rotates_o), 0);
    chk("rst_vld", int'(valid_o), 0);
    chk("rst_done", int'(done_o), 0);
    rst = 1'b0;

    // Directed vectors: load x0 then rotate a.
    for (int i = 0; i < 4; i++) begin
      do_clr();
      sample(tbl[i].x0, 1'b0);
      sample(tbl[i].a, 1'b0);
      chk("first_d", int'(got_d0), int'(tbl[i].d0));
      chk_tol("r_vec", sval(r_o), tbl[i].r, tbl[i].tol);
      chk_tol("y_vec", sval(y_res_o), 0, 16);
    end

    // Column completion, then the next sample is a load.
    do_clr();
    sample(1024, 1'b0);
    sample(1024, 1'b0);
    sample(1024, 1'b0);
    sample(1024, 1'b0);
    chk_tol("col_r", sval(r_o), 2048, 16);
    sample(512, 1'b0);

    // Asynchronous reset in the middle of ITER.
    do_clr();
    sample(4096, 1'b0);
    valid_i = 1'b1;
    a_i = 20'd3072;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_rot", int'(rotates_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", int'(ready_o), 1);
    chk("arst_r", int'(r_o), 0);
    chk("arst_y", int'(y_res_o), 0);
    chk("arst_d", int'(d_o), 0);
    chk("arst_rot", int'(rotates_o), 0);
    chk("arst_vld", int'(valid_o), 0);
    chk("arst_done", int'(done_o), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Synchronous clear while ITER cnt=1.
    sample(4096, 1'b0);
    valid_i = 1'b1;
    a_i = 20'd3072;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    chk("pre_clr_rot", int'(rotates_o), 1);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    chk("clr_rot", int'(rotates_o), 0);
    chk("clr_vld", int'(valid_o), 0);
    chk("clr_ready", int'(ready_o), 1);
    chk("clr_r", int'(r_o), 0);
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_o || rotates_o) nd++;
    end
    chk("clr_quiet", nd, 0);
    model_reset();
    sample(2048, 1'b0);

    // Randomized columns with ignored busy-time valid_i.
    do_clr();
    for (int i = 0; i < 40; i++) begin
      if (m_first) av = int'($urandom_range(0, 8191));
      else         av = int'($urandom_range(0, 16383)) - 8192;
      sample(av, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Busy handling: valid_i held high for 60 cycles.
    do_clr();
    rot_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      av = int'($urandom_range(0, 4095));
      valid_i = 1'b1;
      a_i = 20'(av);
      #2;
      if (ready_o) q.push_back(av);
      if (valid_o) rot_cnt++;
      if (done_o) done_cnt++;
    end
    @(negedge clk);
    valid_i = 1'b0;
    repeat (8) begin
      #2;
      if (valid_o) rot_cnt++;
      if (done_o) done_cnt++;
      @(negedge clk);
    end
    acc_exp = 0;
    tt = 0;
    for (int f = 1, r = 0; tt < 60; ) begin
      acc_exp++;
      if (f == 1) begin
        tt += 2;
        f = 0;
        r = 1;
      end else begin
        tt += 5;
        r++;
        if (r == NR) begin
          r = 0;
          f = 1;
        end
      end
    end
    chk("busy_accepts", q.size(), acc_exp);
    model_reset();
    rot_exp = 0;
    done_exp = 0;
    foreach (q[i]) begin
      if (m_first) begin
        m_x = q[i];
        m_first = 1'b0;
        m_rows = 1;
      end else begin
        model_rot(m_x, q[i], xo, yo, dd);
        m_x = xo;
        rot_exp++;
        m_rows++;
        if (m_rows == NR) begin
          done_exp++;
          m_rows = 0;
          m_first = 1'b1;
        end
      end
    end
    chk("busy_rots", rot_cnt, rot_exp);
    chk("busy_dones", done_cnt, done_exp);
    chk("busy_r", sval(r_o), m_x);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
